// File: rtl/serial_ripple_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_ripple_subtractor_if
// Description : Request/result bundle for the bit-serial subtractor.
//               master : drives start/a/b/bin, observes busy/done/results.
//               slave  : the subtractor itself.
//   start  request, sampled by the slave on a rising edge when not busy
//   a, b   minuend / subtrahend (WIDTH bits), bin borrow-in
//   busy   bit-steps in progress
//   done   one-cycle pulse, results updated
//   diff   a - b - bin mod 2^WIDTH, bout borrow-out, ovf signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_ripple_subtractor
// Description : Bit-serial a - b - bin. One full-subtractor stage plus a
//               registered borrow processes one bit per clock, LSB first.
//               Operands are captured on an accepted start; after WIDTH
//               bit-steps the difference, borrow-out and two's-complement
//               overflow are published together with a one-cycle done pulse.
// Ports       : clk  rising-edge clock
//               rst  asynchronous, active-high reset
//               bus  serial_ripple_subtractor_if.slave
//                    (start/a/b/bin in; busy/done/diff/bout/ovf out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  wire                          clk,
    input  wire                          rst,
    serial_ripple_subtractor_if.slave    bus
);

    // Counter must hold values 0..WIDTH without wrapping.
    localparam int               c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;     // minuend shift register, LSB consumed first
    logic [WIDTH-1:0]   r_b_sh;     // subtrahend shift register
    logic [WIDTH-1:0]   r_res;      // partial result, filled from the MSB end
    logic               r_br;       // running borrow
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;    // operand sign bits kept for overflow
    logic               r_b_msb;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    // Full-subtractor stage on the current LSBs.
    logic               w_ai;
    logic               w_bi;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_accept;

    assign w_ai       = r_a_sh[0];
    assign w_bi       = r_b_sh[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // After the last step the newest bit lands in the MSB, so this is the
    // full result on the completing edge.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign w_accept   = bus.start && (r_state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_res   <= '0;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // start is deliberately not looked at here.
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_next;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        // Overflow only possible when operand signs differ;
                        // it shows as a result sign unlike the minuend's.
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_ripple_subtractor
// Description : Self-checking bench for serial_ripple_subtractor at WIDTH=4
//               (directed table, corner sequences, exhaustive sweep) and
//               WIDTH=16 (random operands against an arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_ripple_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor_if #(.WIDTH(4))  if4 ();
    serial_ripple_subtractor_if #(.WIDTH(16)) if16 ();

    serial_ripple_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    serial_ripple_subtractor #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: done never seen within cycle budget", nm);
    endtask

    // Issue one WIDTH=4 operation and compare {bout,diff,ovf}. With full=1 the
    // busy length, busy-at-done and single-cycle done are also checked.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       input logic [3:0] ed, input logic eb, input logic eo,
                       input bit full, input string nm);
        int n;
        int nb;
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b; if4.bin = bin;
        @(negedge clk);
        if4.start = 1'b0;
        n = 0; nb = 0;
        while (!if4.done && n < 20) begin
            if (if4.busy) nb++;
            n++;
            @(negedge clk);
        end
        if (!if4.done) begin
            timeout(nm);
        end else begin
            if (full) begin
                check({nm, " busy_cycles"}, nb, 4);
                check({nm, " busy_at_done"}, {31'd0, if4.busy}, 0);
            end
            check({nm, " result"}, {29'd0, if4.bout, if4.diff, if4.ovf}, {29'd0, eb, ed, eo});
            if (full) begin
                @(negedge clk);
                check({nm, " done_single"}, {31'd0, if4.done}, 0);
            end
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int n;
        int sa, sb, sr;
        logic [16:0] m;
        logic        eo;
        m  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = sa - sb - int'(bin);
        eo = (sr > 32767) || (sr < -32768);
        @(negedge clk);
        if16.start = 1'b1; if16.a = a; if16.b = b; if16.bin = bin;
        @(negedge clk);
        if16.start = 1'b0;
        n = 0;
        while (!if16.done && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!if16.done) timeout("w16");
        else check("w16 result", {14'd0, if16.bout, if16.diff, if16.ovf}, {14'd0, m[16], m[15:0], eo});
    endtask

    initial begin
        int          n;
        bit          seen;
        logic [4:0]  m;
        int          sa, sb, sr;
        logic        eo;

        vecs[0] = '{4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[1] = '{4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0};
        vecs[2] = '{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
        vecs[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};
        vecs[5] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[7] = '{4'h8, 4'h0, 1'b1, 4'h7, 1'b0, 1'b1};

        if4.start = 1'b0;  if4.a = '0;  if4.b = '0;  if4.bin = 1'b0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;

        // Reset state
        #12;
        check("reset outputs", {24'd0, if4.busy, if4.done, if4.diff, if4.bout, if4.ovf}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++)
            op4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout,
                vecs[i].ovf, 1'b1, $sformatf("vec%0d", i));

        // Results hold while idle
        repeat (3) @(negedge clk);
        check("hold", {27'd0, if4.bout, if4.diff}, {27'd0, 1'b0, 4'h7});

        // start re-asserted with new operands during RUN of (9,2) is ignored
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd9; if4.b = 4'd2; if4.bin = 1'b0;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd1; if4.b = 4'd1;
        @(negedge clk);
        if4.start = 1'b0;
        n = 0;
        while (!if4.done && n < 20) begin n++; @(negedge clk); end
        if (!if4.done) timeout("ignore");
        else check("ignore result", {27'd0, if4.bout, if4.diff}, {27'd0, 1'b0, 4'd7});

        // Back-to-back: start held through DONE launches the next op at once
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd5; if4.b = 4'd1; if4.bin = 1'b0;
        n = 0;
        @(negedge clk);
        while (!if4.done && n < 20) begin n++; @(negedge clk); end
        if (!if4.done) timeout("b2b first");
        else begin
            check("b2b first", {27'd0, if4.bout, if4.diff}, {27'd0, 1'b0, 4'd4});
            if4.a = 4'd2; if4.b = 4'd3;
            @(negedge clk);
            check("b2b restart", {30'd0, if4.done, if4.busy}, {30'd0, 1'b0, 1'b1});
            if4.start = 1'b0;
            n = 0;
            while (!if4.done && n < 20) begin n++; @(negedge clk); end
            if (!if4.done) timeout("b2b second");
            else check("b2b second", {26'd0, if4.bout, if4.diff, if4.ovf}, {26'd0, 1'b1, 4'hF, 1'b0});
        end

        // Asynchronous reset after two bit-steps
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd6; if4.b = 4'd1; if4.bin = 1'b0;
        @(posedge clk);
        #1 if4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async reset", {24'd0, if4.busy, if4.done, if4.diff, if4.bout, if4.ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if4.done) seen = 1'b1;
        end
        check("no done after reset", {31'd0, seen}, 0);
        op4(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, "post reset");

        // Exhaustive WIDTH=4
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    m  = 5'(a - b - c);
                    sa = (a >= 8) ? a - 16 : a;
                    sb = (b >= 8) ? b - 16 : b;
                    sr = sa - sb - c;
                    eo = (sr > 7) || (sr < -8);
                    op4(4'(a), 4'(b), 1'(c), m[3:0], m[4], eo, 1'b0,
                        $sformatf("ex a=%0d b=%0d bin=%0d", a, b, c));
                end
            end
        end

        // WIDTH=16 corners and random
        op16(16'h8000, 16'h0001, 1'b0);
        op16(16'h7FFF, 16'hFFFF, 1'b0);
        op16(16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 40; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial counterpart to the team's parallel ripple-carry adder. Computes a - b - bin one bit per clock through a single full-subtractor stage and a registered borrow, LSB first.
- Used where area matters more than latency.
- Operands are captured on a start handshake. Difference, borrow-out and signed overflow are presented registered, with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled at rising edge when not busy
a      input   WIDTH  minuend, captured at accepted start
b      input   WIDTH  subtrahend, captured at accepted start
bin    input   1      borrow-in, captured at accepted start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse: results updated
diff   output  WIDTH  registered difference, a - b - bin mod 2^WIDTH
bout   output  1      registered borrow-out (1 when a < b + bin unsigned)
ovf    output  1      registered two's-complement overflow

Behaviour:
- Reset: asynchronous; all outputs and internal registers go to 0 immediately. State returns to IDLE.
  - Reset mid-operation aborts the operation. No done pulse is issued. diff/bout/ovf = 0.
- States are IDLE, RUN and DONE.
  - IDLE/DONE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit-steps.
  - DONE -> IDLE after one cycle if start=0.
- Start acceptance (edge k, state IDLE or DONE):
  - Load shift registers with a and b.
  - Borrow register <= bin.
  - Bit counter <= 0.
  - Latch a[WIDTH-1] and b[WIDTH-1] for the overflow calculation.
  - State <= RUN.
- start while in RUN is ignored. Operands are not re-sampled.
- RUN bit-step at each edge k+1 .. k+WIDTH, using ai, bi = shift-register LSBs and br = borrow register:
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - d is shifted into the MSB of an internal result register.
  - Operand registers shift right. Counter increments.
- Completion at edge k+WIDTH:
  - diff <= final result register (including the bit computed on that edge).
  - bout <= final borrow.
  - ovf <= (a_msb != b_msb) & (diff_msb != a_msb).
  - State <= DONE.
- Latency: done = 1 during exactly the one cycle following edge k+WIDTH.
- busy = 1 during cycles after edges k .. k+WIDTH-1 (exactly WIDTH cycles), and 0 in IDLE and DONE.
- diff/bout/ovf change only at completion or reset, and hold between operations.
- Back-to-back operation: start=1 during the DONE cycle is accepted at the next edge. done then drops and busy rises. No idle bubble is required.
- Counter width is ceil(log2(WIDTH))+1. No wrap-around occurs within an operation.
- Intermediate partial results are never visible on diff.

Test Plan:
- WIDTH=4: a=7, b=3, bin=0, start pulsed -> busy high 4 cycles, then done high 1 cycle with diff=4, bout=0, ovf=0; done is never high for 2 consecutive cycles.
- a=3, b=5, bin=0 -> diff=4'hE, bout=1, ovf=0. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1, ovf=0.
- Signed overflow: a=4'h8, b=4'h1 -> diff=4'h7, bout=0, ovf=1. a=4'h7, b=4'hF -> diff=4'h8, bout=1, ovf=1.
- start re-asserted with a=1, b=1 during RUN of the (9,2) operation -> ignored; result diff=7. start held high through the DONE cycle -> the next operation begins immediately, with busy rising the edge after done.
- rst asserted asynchronously mid-RUN (after 2 bit-steps) -> busy, done, diff, bout and ovf read 0 before the next clock edge, and no done pulse follows. A new start afterwards completes correctly.
- Exhaustive check: all 512 (a, b, bin) combinations at WIDTH=4 compared against a reference model of {bout, diff} = a - b - bin (5-bit). Repeat randomly at WIDTH=16.
